// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART receiver and transmitter: absorbs receiver bursts,
// hands bytes to the transmitter first-word-fall-through, and flags dropped writes.
module uart_tx_fifo #(
    parameter int DW      = 8,
    parameter int LGDEPTH = 4
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [DW-1:0]      i_data,
    output logic               o_tx_valid,
    output logic [DW-1:0]      o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_full,
    output logic               o_empty,
    output logic [LGDEPTH:0]   o_fill,
    output logic               o_overflow
);

    localparam int                 DEPTH     = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0]   FILL_MAX  = (LGDEPTH+1)'(DEPTH);
    localparam logic [LGDEPTH:0]   FILL_ONE  = (LGDEPTH+1)'(1);
    localparam logic [LGDEPTH-1:0] PTR_ONE   = LGDEPTH'(1);

    logic [DW-1:0]      mem_q [DEPTH];
    logic [LGDEPTH-1:0] wptr_q, wptr_d;
    logic [LGDEPTH-1:0] rptr_q, rptr_d;
    logic [LGDEPTH:0]   fill_q, fill_d;
    logic               overflow_q, overflow_d;

    logic full, empty, pop, push;

    assign full  = (fill_q == FILL_MAX);
    assign empty = (fill_q == '0);
    assign pop   = !empty && i_tx_ready;
    // A pop frees a slot in the same cycle, so a write while full still lands.
    assign push  = i_wr && (!full || pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;

        if (push) wptr_d = wptr_q + PTR_ONE;
        if (pop)  rptr_d = rptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase

        if (i_wr && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not cleared on reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!i_reset && push) mem_q[wptr_q] <= i_data;
    end

    assign o_tx_valid = !empty;
    assign o_tx_data  = mem_q[rptr_q];
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_fill     = fill_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for the basic handshake,
// then hand-written fill/drain, overflow, full push+pop and streaming sequences.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       i_reset, i_wr, i_tx_ready;
    logic [7:0] i_data;
    logic       o_tx_valid, o_full, o_empty, o_overflow;
    logic [7:0] o_tx_data;
    logic [4:0] o_fill;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_fifo #(.DW(8), .LGDEPTH(4)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_fill     (o_fill),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] data;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_empty;
        logic [4:0] e_fill;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [7:0] d, input logic rdy);
        i_reset    = rst;
        i_wr       = wr;
        i_data     = d;
        i_tx_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_range(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, base + 8'(i), 1'b0);
            check("fill_count", 32'(o_fill), 32'(i + 1));
        end
        check("full_flag", 32'(o_full), 32'd1);
        check("full_fill", 32'(o_fill), 32'd16);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h5B, 1'b1, 1'b1, 8'h5B, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h5C, 1'b0, 1'b1, 8'h5B, 1'b0, 1'b0, 5'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};

        i_reset = 1'b1; i_wr = 1'b0; i_data = 8'h00; i_tx_ready = 1'b0;
        #1;

        for (int v = 0; v < 11; v++) begin
            step(vecs[v].rst, vecs[v].wr, vecs[v].data, vecs[v].rdy);
            check($sformatf("vec%0d_valid", v), 32'(o_tx_valid), 32'(vecs[v].e_valid));
            check($sformatf("vec%0d_full", v),  32'(o_full),     32'(vecs[v].e_full));
            check($sformatf("vec%0d_empty", v), 32'(o_empty),    32'(vecs[v].e_empty));
            check($sformatf("vec%0d_fill", v),  32'(o_fill),     32'(vecs[v].e_fill));
            check($sformatf("vec%0d_ovf", v),   32'(o_overflow), 32'(vecs[v].e_ovf));
            if (vecs[v].e_valid)
                check($sformatf("vec%0d_data", v), 32'(o_tx_data), 32'(vecs[v].e_data));
        end

        // Fill to full then drain in order.
        fill_range(8'h00);
        for (int i = 0; i < 16; i++) begin
            check("order_valid", 32'(o_tx_valid), 32'd1);
            check("order_data", 32'(o_tx_data), 32'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("order_empty", 32'(o_empty), 32'd1);
        check("order_ovf", 32'(o_overflow), 32'd0);

        // Dropped write when full without a pop.
        fill_range(8'h10);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_fill", 32'(o_fill), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_data", 32'(o_tx_data), 32'(8'h10 + 8'(i)));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("ovf_drain_empty", 32'(o_empty), 32'd1);
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        check("ovf_reset_ovf", 32'(o_overflow), 32'd0);
        check("ovf_reset_empty", 32'(o_empty), 32'd1);
        check("ovf_reset_fill", 32'(o_fill), 32'd0);

        // Write while full with a simultaneous pop.
        fill_range(8'h20);
        step(1'b0, 1'b1, 8'hBB, 1'b1);
        check("fpp_fill", 32'(o_fill), 32'd16);
        check("fpp_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("fpp_data", 32'(o_tx_data), (i < 15) ? 32'(8'h21 + 8'(i)) : 32'hBB);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("fpp_empty", 32'(o_empty), 32'd1);

        // Streaming: one push and one pop per cycle, pointers wrap repeatedly.
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b1);
            check("stream_valid", 32'(o_tx_valid), 32'd1);
            check("stream_data", 32'(o_tx_data), 32'(k));
            check("stream_fill", 32'(o_fill), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("stream_end_empty", 32'(o_empty), 32'd1);

        // Ready pulse while empty must not move anything.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("idle_rdy_fill", 32'(o_fill), 32'd0);
        check("idle_rdy_empty", 32'(o_empty), 32'd1);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        check("idle_rdy_next_data", 32'(o_tx_data), 32'h77);
        check("idle_rdy_next_fill", 32'(o_fill), 32'd1);
        check("idle_rdy_ovf", 32'(o_overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
